snake_engine: RTL and testbench
===============================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter MAX_LEN, default 128, meaning segment capacity (power of two, 4..128).
REQ-002 SHALL have parameter INIT_LEN, default 4, meaning length after reset or restart.
REQ-003 SHALL have parameters START_X, default 80, and START_Y, default 60, meaning the initial head cell.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock (CLOCK_50 domain).
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port frame_update, input, 1: one-cycle move tick from the frame updater.
REQ-007 SHALL have port direction, input, 5: [0] up, [1] down, [2] left, [3] right (one-hot), [4] pause.
REQ-008 SHALL have port ingame, input, 1: game active; a 0->1 transition restarts the game.
REQ-009 SHALL have ports apple_x, input, 8, and apple_y, input, 7: the apple cell.
REQ-010 SHALL have ports x_pointer, input, 8, and y_pointer, input, 7: the raster query cell from the refresher.
REQ-011 SHALL have ports snake_pixel and head_pixel, output, 1 each: the query cell is body/head.
REQ-012 SHALL have ports busy, game_over and apple_eaten, output, 1 each; length, output, 8.

Function
REQ-013 SHALL hold segment arrays seg_x[0:MAX_LEN-1] (8b) and seg_y[0:MAX_LEN-1] (7b); index 0 is the head.
REQ-014 SHALL use FSM IDLE -> CHECK -> SHIFT -> IDLE, plus DEAD; busy=1 in CHECK and SHIFT.
REQ-015 SHALL, in IDLE, on frame_update with ingame=1, direction[4]=0 and game_over=0, latch the heading and compute next_head, then enter CHECK; otherwise it SHALL ignore the tick.
REQ-016 SHALL update the heading only when direction[3:0] is one-hot and not opposite to the current heading; zero, multi-hot or reversal inputs SHALL keep the heading (initial heading: right).
REQ-017 SHALL set grow=1 when next_head equals (apple_x,apple_y).
REQ-018 SHALL, in CHECK, compare next_head against seg[i], one index per cycle, for i=0..length-2 (i=0..length-1 when grow=1); on a match it SHALL enter DEAD.
REQ-019 SHALL, in SHIFT, copy seg[i]<=seg[i-1] one index per cycle, from i=length-1 (i=length if grow=1 and length<MAX_LEN) down to 1, then write next_head to seg[0] and return to IDLE.
REQ-020 SHALL, on commit with grow=1, pulse apple_eaten for exactly one cycle and increment length, saturating at MAX_LEN (pulse still issued at saturation).
REQ-021 SHALL ignore frame_update while busy=1; ticks SHALL NOT be queued.
REQ-022 SHALL register snake_pixel (any i<length matching the query cell) and head_pixel (seg[0] matches) with one-cycle latency; their values are defined only while busy=0.
REQ-023 SHALL, in DEAD, assert game_over and freeze the arrays; it SHALL leave DEAD only on reset or an ingame 0->1 restart.
REQ-024 SHALL, on an ingame 0->1 transition (any state), reinitialise the arrays, length and heading as reset does, clear game_over and enter IDLE.

Reset
REQ-025 SHALL, on reset, set seg[i]=(START_X-i, START_Y) for i<INIT_LEN, length=INIT_LEN, heading=right, state=IDLE, and all 1-bit outputs=0.
REQ-026 SHALL abort any CHECK/SHIFT sequence in progress when reset asserts mid-move.

Configuration
REQ-027 SHALL, with macro SNAKE_WRAP_EN defined, wrap the head at the borders (x 159<->0, y 119<->0) without game over.
REQ-028 SHALL, without SNAKE_WRAP_EN, enter DEAD when next_head leaves x 0..159 or y 0..119, skipping CHECK.

Verification
REQ-029 SHALL verify: reset, query (80,60) -> snake_pixel=1 and head_pixel=1 next cycle; (77,60) -> snake_pixel=1; (76,60) -> snake_pixel=0; length=4.
REQ-030 SHALL verify: one tick with direction=0 -> busy pulses, then head at (81,60) and (77,60) reads 0.
REQ-031 SHALL verify: heading right, direction=left tick -> head (82,60); then direction=up tick -> head (82,59).
REQ-032 SHALL verify: apple at (81,60) with one tick -> apple_eaten high for 1 cycle, length=5, (77,60) still reads 1.
REQ-033 SHALL verify: head at (159,60) heading right plus one tick -> game_over=1 without the macro, and head at (0,60) with SNAKE_WRAP_EN.
REQ-034 SHALL verify: grow to length 6, then ticks up, left, down -> game_over=1; then ingame toggled 0->1 -> game_over=0 and length=4.

Source files
------------

// File: rtl/snake_engine.sv
// Snake game core: segment arrays with a sequential per-segment collision check and tail-to-head shift.
// Build macro SNAKE_WRAP_EN makes the head wrap at the playfield borders instead of ending the game.
module snake_engine #(
  parameter int MAX_LEN  = 128,
  parameter int INIT_LEN = 4,
  parameter int START_X  = 80,
  parameter int START_Y  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_update,
  input  logic [4:0] direction,
  input  logic       ingame,
  input  logic [7:0] apple_x,
  input  logic [6:0] apple_y,
  input  logic [7:0] x_pointer,
  input  logic [6:0] y_pointer,
  output logic       snake_pixel,
  output logic       head_pixel,
  output logic       busy,
  output logic       game_over,
  output logic       apple_eaten,
  output logic [7:0] length
);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
  localparam logic [7:0]    MAX_LEN_L = 8'(MAX_LEN);
  localparam logic [7:0]    INIT_LEN_L = 8'(INIT_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, SHIFT = 2'd2, DEAD = 2'd3} state_t;

  state_t        state_r, state_s;
  logic [7:0]    seg_x_r [MAX_LEN];
  logic [6:0]    seg_y_r [MAX_LEN];
  logic [3:0]    heading_r, heading_s;
  logic [7:0]    nh_x_r, nh_x_s;
  logic [6:0]    nh_y_r, nh_y_s;
  logic          grow_r, grow_s;
  logic [IW-1:0] idx_r, shift_start_s;
  logic [7:0]    length_r, check_lim_s;
  logic          ingame_d_r, restart_s, tick_s, hit_s, check_last_s, edge_s, oob_s;
  logic          busy_s, game_over_s, eat_s, body_hit_s;
  logic          snake_pixel_r, head_pixel_r, busy_r, game_over_r, apple_eaten_r;

  function automatic logic [7:0] init_x(input int i);
    return (i < INIT_LEN) ? 8'(START_X - i) : 8'd0;
  endfunction

  function automatic logic [6:0] init_y(input int i);
    return (i < INIT_LEN) ? 7'(START_Y) : 7'd0;
  endfunction

  assign restart_s     = ingame & ~ingame_d_r;
  assign tick_s        = frame_update & ingame & ~direction[4] & ~game_over_r;
  assign hit_s         = (nh_x_r == seg_x_r[idx_r]) && (nh_y_r == seg_y_r[idx_r]);
  assign check_lim_s   = grow_r ? (length_r - 8'd1) : (length_r - 8'd2);
  assign check_last_s  = (8'(idx_r) == check_lim_s);
  assign shift_start_s = (grow_r && (length_r < MAX_LEN_L)) ? IW'(length_r) : IW'(length_r - 8'd1);
  assign grow_s        = (nh_x_s == apple_x) && (nh_y_s == apple_y);

`ifdef SNAKE_WRAP_EN
  assign oob_s = 1'b0;
`else
  assign oob_s = edge_s;
`endif

  // Heading filter (one-hot, non-reversing) and candidate head cell with border wrap values.
  always_comb begin
    heading_s = heading_r;
    if ($onehot(direction[3:0]) &&
        (direction[3:0] != {heading_r[2], heading_r[3], heading_r[0], heading_r[1]})) begin
      heading_s = direction[3:0];
    end else begin
      heading_s = heading_r;
    end
    nh_x_s = seg_x_r[0];
    nh_y_s = seg_y_r[0];
    edge_s = 1'b0;
    case (heading_s)
      4'b0001: if (seg_y_r[0] == 7'd0)   begin edge_s = 1'b1; nh_y_s = 7'd119; end
               else                            nh_y_s = seg_y_r[0] - 7'd1;
      4'b0010: if (seg_y_r[0] == 7'd119) begin edge_s = 1'b1; nh_y_s = 7'd0;   end
               else                            nh_y_s = seg_y_r[0] + 7'd1;
      4'b0100: if (seg_x_r[0] == 8'd0)   begin edge_s = 1'b1; nh_x_s = 8'd159; end
               else                            nh_x_s = seg_x_r[0] - 8'd1;
      4'b1000: if (seg_x_r[0] == 8'd159) begin edge_s = 1'b1; nh_x_s = 8'd0;   end
               else                            nh_x_s = seg_x_r[0] + 8'd1;
      default: edge_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic; a restart overrides every state.
  always_comb begin
    state_s = state_r;
    if (restart_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (tick_s) state_s = oob_s ? DEAD : CHECK;
                 else        state_s = IDLE;
        CHECK:   if (hit_s)             state_s = DEAD;
                 else if (check_last_s) state_s = SHIFT;
                 else                   state_s = CHECK;
        SHIFT:   if (idx_r == IDX_ZERO) state_s = IDLE;
                 else                   state_s = SHIFT;
        DEAD:    state_s = DEAD;
        default: state_s = IDLE;
      endcase
    end
  end

  // Output decode, taken from the next state so the registered flags line up with the state.
  always_comb begin
    busy_s      = (state_s == CHECK) || (state_s == SHIFT);
    game_over_s = (state_s == DEAD);
    eat_s       = (state_r == SHIFT) && (idx_r == IDX_ZERO) && grow_r && !restart_s;
  end

  // Body hit for the raster query over the live segments.
  always_comb begin
    body_hit_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((8'(i) < length_r) && (seg_x_r[i] == x_pointer) && (seg_y_r[i] == y_pointer)) body_hit_s = 1'b1;
      else                                                                                body_hit_s = body_hit_s;
    end
  end

  // Segment arrays, move context and length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= init_x(i);
        seg_y_r[i] <= init_y(i);
      end
      heading_r  <= 4'b1000;
      length_r   <= INIT_LEN_L;
      nh_x_r     <= 8'd0;
      nh_y_r     <= 7'd0;
      grow_r     <= 1'b0;
      idx_r      <= IDX_ZERO;
      ingame_d_r <= 1'b0;
    end else begin
      ingame_d_r <= ingame;
      if (restart_s) begin
        for (int i = 0; i < MAX_LEN; i++) begin
          seg_x_r[i] <= init_x(i);
          seg_y_r[i] <= init_y(i);
        end
        heading_r <= 4'b1000;
        length_r  <= INIT_LEN_L;
        grow_r    <= 1'b0;
        idx_r     <= IDX_ZERO;
      end else begin
        case (state_r)
          IDLE: if (tick_s) begin
                  heading_r <= heading_s;
                  nh_x_r    <= nh_x_s;
                  nh_y_r    <= nh_y_s;
                  grow_r    <= grow_s;
                  idx_r     <= IDX_ZERO;
                end
          CHECK: idx_r <= check_last_s ? shift_start_s : (idx_r + IDX_ONE);
          SHIFT: if (idx_r == IDX_ZERO) begin
                   seg_x_r[0] <= nh_x_r;
                   seg_y_r[0] <= nh_y_r;
                   if (grow_r && (length_r < MAX_LEN_L)) length_r <= length_r + 8'd1;
                 end else begin
                   seg_x_r[idx_r] <= seg_x_r[idx_r - IDX_ONE];
                   seg_y_r[idx_r] <= seg_y_r[idx_r - IDX_ONE];
                   idx_r          <= idx_r - IDX_ONE;
                 end
          default: idx_r <= idx_r;
        endcase
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snake_pixel_r <= 1'b0;
      head_pixel_r  <= 1'b0;
      busy_r        <= 1'b0;
      game_over_r   <= 1'b0;
      apple_eaten_r <= 1'b0;
    end else begin
      snake_pixel_r <= body_hit_s;
      head_pixel_r  <= (seg_x_r[0] == x_pointer) && (seg_y_r[0] == y_pointer);
      busy_r        <= busy_s;
      game_over_r   <= game_over_s;
      apple_eaten_r <= eat_s;
    end
  end

  assign snake_pixel = snake_pixel_r;
  assign head_pixel  = head_pixel_r;
  assign busy        = busy_r;
  assign game_over   = game_over_r;
  assign apple_eaten = apple_eaten_r;
  assign length      = length_r;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: a queue-based snake model plus directed and random moves.
module tb_snake_engine;
  localparam int MAXL  = 8;
  localparam int INITL = 4;

  logic       clk = 1'b0;
  logic       reset, frame_update, ingame;
  logic [4:0] direction;
  logic [7:0] apple_x, x_pointer;
  logic [6:0] apple_y, y_pointer;
  logic       snake_pixel, head_pixel, busy, game_over, apple_eaten;
  logic [7:0] length;

  always #5 clk = ~clk;

  snake_engine #(.MAX_LEN(MAXL), .INIT_LEN(INITL), .START_X(80), .START_Y(60)) dut (
    .clk(clk), .reset(reset), .frame_update(frame_update), .direction(direction),
    .ingame(ingame), .apple_x(apple_x), .apple_y(apple_y), .x_pointer(x_pointer),
    .y_pointer(y_pointer), .snake_pixel(snake_pixel), .head_pixel(head_pixel),
    .busy(busy), .game_over(game_over), .apple_eaten(apple_eaten), .length(length)
  );

  int n_checks = 0;
  int n_errors = 0;
  int mx[$];
  int my[$];
  int hdx, hdy;
  bit mdead;
  bit exp_valid = 1'b0;
  bit hold_ptr = 1'b0;
  logic [7:0] req_x = 8'd0;
  logic [6:0] req_y = 7'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mx.delete();
    my.delete();
    for (int i = 0; i < INITL; i++) begin
      mx.push_back(80 - i);
      my.push_back(60);
    end
    hdx = 1;
    hdy = 0;
    mdead = 1'b0;
  endfunction

  function automatic bit model_body(input int x, input int y);
    foreach (mx[i]) if (mx[i] == x && my[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void pred(input logic [4:0] dir, output int nx, output int ny,
                               output int ndx, output int ndy, output bit oob);
    int dx, dy;
    ndx = hdx;
    ndy = hdy;
    if ($countones(dir[3:0]) == 1) begin
      dx = dir[3] ? 1 : (dir[2] ? -1 : 0);
      dy = dir[1] ? 1 : (dir[0] ? -1 : 0);
      if (!(dx == -hdx && dy == -hdy)) begin
        ndx = dx;
        ndy = dy;
      end
    end
    nx = mx[0] + ndx;
    ny = my[0] + ndy;
    oob = 1'b0;
    if (nx < 0 || nx > 159 || ny < 0 || ny > 119) begin
`ifdef SNAKE_WRAP_EN
      nx = (nx + 160) % 160;
      ny = (ny + 120) % 120;
`else
      oob = 1'b1;
`endif
    end
  endfunction

  function automatic void model_step(input logic [4:0] dir, output bit acc, output bit oob, output bit eat);
    int nx, ny, ndx, ndy, n, lim;
    bit grow, hit;
    acc = ingame && !dir[4] && !mdead;
    oob = 1'b0;
    eat = 1'b0;
    if (acc) begin
      pred(dir, nx, ny, ndx, ndy, oob);
      hdx = ndx;
      hdy = ndy;
      if (oob) begin
        mdead = 1'b1;
      end else begin
        grow = (nx == int'(apple_x)) && (ny == int'(apple_y));
        n = mx.size();
        lim = grow ? n - 1 : n - 2;
        hit = 1'b0;
        for (int i = 0; i <= lim; i++) if (mx[i] == nx && my[i] == ny) hit = 1'b1;
        if (hit) begin
          mdead = 1'b1;
        end else begin
          mx.push_front(nx);
          my.push_front(ny);
          if (!(grow && n < MAXL)) begin
            void'(mx.pop_back());
            void'(my.pop_back());
          end
          eat = grow;
        end
      end
    end
  endfunction

  // Query pointer: held by directed queries, otherwise random or near a body cell.
  always begin : ptr_drive
    int k;
    @(posedge clk);
    #2;
    if (hold_ptr) begin
      x_pointer = req_x;
      y_pointer = req_y;
    end else if (mx.size() > 0 && $urandom_range(0, 1) == 0) begin
      k = int'($urandom_range(0, mx.size() - 1));
      x_pointer = 8'(mx[k] + int'($urandom_range(0, 2)) - 1);
      y_pointer = 7'(my[k] + int'($urandom_range(0, 2)) - 1);
    end else begin
      x_pointer = 8'($urandom_range(0, 159));
      y_pointer = 7'($urandom_range(0, 119));
    end
  end

  // Every idle cycle: outputs against the model for the pointer seen at this edge.
  always begin : compare
    int qx, qy, el;
    bit es, eh, eg;
    @(posedge clk);
    if (exp_valid && !reset) begin
      qx = int'(x_pointer);
      qy = int'(y_pointer);
      es = model_body(qx, qy);
      eh = (mx[0] == qx) && (my[0] == qy);
      el = mx.size();
      eg = mdead;
      #1;
      check("snake_pixel", snake_pixel, es);
      check("head_pixel", head_pixel, eh);
      check("length", length, el);
      check("game_over", game_over, eg);
      check("busy_idle", busy, 0);
      check("apple_idle", apple_eaten, 0);
    end
  end

  task automatic query(input int x, input int y, input bit es, input bit eh);
    req_x = 8'(x);
    req_y = 7'(y);
    hold_ptr = 1'b1;
    @(posedge clk);
    #3;
    @(posedge clk);
    #1;
    check("query_snake", snake_pixel, es);
    check("query_head", head_pixel, eh);
    hold_ptr = 1'b0;
  endtask

  task automatic do_move(input logic [4:0] dir, input bit extra);
    bit acc, oob, eat;
    int n;
    @(negedge clk);
    exp_valid = 1'b0;
    direction = dir;
    frame_update = 1'b1;
    model_step(dir, acc, oob, eat);
    @(negedge clk);
    frame_update = 1'b0;
    check("busy_after_tick", busy, acc && !oob);
    if (extra && busy) begin
      frame_update = 1'b1;
      @(negedge clk);
      frame_update = 1'b0;
    end
    n = 0;
    while (busy && n < 4 * MAXL + 16) begin
      @(negedge clk);
      n++;
    end
    check("move_done", busy, 0);
    check("apple_eaten", apple_eaten, eat);
    check("game_over_move", game_over, mdead);
    @(negedge clk);
    check("apple_once", apple_eaten, 0);
    @(negedge clk);
    exp_valid = 1'b1;
  endtask

  task automatic do_restart();
    @(negedge clk);
    exp_valid = 1'b0;
    ingame = 1'b0;
    @(negedge clk);
    ingame = 1'b1;
    @(negedge clk);
    model_reset();
    check("restart_go", game_over, 0);
    check("restart_len", length, INITL);
    @(negedge clk);
    exp_valid = 1'b1;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int nx, ny, ndx, ndy, r;
    bit oob;
    logic [4:0] dir;
    reset = 1'b1; frame_update = 1'b0; direction = 5'd0; ingame = 1'b1;
    apple_x = 8'd10; apple_y = 7'd10;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_go", game_over, 0);
    check("rst_apple", apple_eaten, 0);
    check("rst_snake", snake_pixel, 0);
    check("rst_head", head_pixel, 0);
    check("rst_len", length, INITL);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    exp_valid = 1'b1;

    query(80, 60, 1, 1);
    query(77, 60, 1, 0);
    query(76, 60, 0, 0);
    check("len4", length, 4);

    do_move(5'b00000, 1'b0);
    check("model_head_x", mx[0], 81);
    query(81, 60, 1, 1);
    query(77, 60, 0, 0);

    do_move(5'b00100, 1'b0);
    check("model_rev_x", mx[0], 82);
    query(82, 60, 1, 1);
    do_move(5'b00001, 1'b0);
    check("model_up_y", my[0], 59);
    query(82, 59, 1, 1);
    query(82, 60, 1, 0);

    do_restart();
    apple_x = 8'd81; apple_y = 7'd60;
    do_move(5'b00000, 1'b1);
    check("grow_len5", length, 5);
    query(77, 60, 1, 0);
    query(81, 60, 1, 1);
    apple_x = 8'd82;
    do_move(5'b00000, 1'b0);
    check("grow_len6", length, 6);
    apple_x = 8'd10; apple_y = 7'd10;
    do_move(5'b00001, 1'b0);
    do_move(5'b00100, 1'b0);
    do_move(5'b00010, 1'b0);
    check("self_hit_go", game_over, 1);
    do_move(5'b01000, 1'b0);
    do_restart();
    check("restart_len4", length, 4);

    do_move(5'b11000, 1'b0);
    query(80, 60, 1, 1);
    do_move(5'b00011, 1'b0);
    check("multihot_x", mx[0], 81);

    do_restart();
    for (int i = 0; i < 79; i++) do_move(5'b01000, 1'b0);
    query(159, 60, 1, 1);
    do_move(5'b01000, 1'b0);
`ifdef SNAKE_WRAP_EN
    check("wrap_go", game_over, 0);
    query(0, 60, 1, 1);
`else
    check("border_go", game_over, 1);
    query(159, 60, 1, 1);
`endif

    do_restart();
    @(negedge clk);
    exp_valid = 1'b0;
    direction = 5'b00000;
    frame_update = 1'b1;
    @(negedge clk);
    frame_update = 1'b0;
    check("midmove_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_len", length, INITL);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    exp_valid = 1'b1;
    query(80, 60, 1, 1);

    for (int it = 0; it < 400; it++) begin
      if (mdead) do_restart();
      r = int'($urandom_range(0, 9));
      if (r < 8)       dir = 5'(1 << $urandom_range(0, 3));
      else if (r == 8) dir = 5'd0;
      else             dir = 5'($urandom_range(0, 31));
      pred(dir, nx, ny, ndx, ndy, oob);
      if ($urandom_range(0, 2) == 0 && !oob) begin
        apple_x = 8'(nx);
        apple_y = 7'(ny);
      end else begin
        apple_x = 8'($urandom_range(0, 159));
        apple_y = 7'($urandom_range(0, 119));
      end
      do_move(dir, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
